// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage of the in-order core.
// Owns the fetch PC, issues one-word requests to instruction memory and
// presents the returned word plus the IF/ID payload to decode.
// Optional feature: define IF_STATIC_PRED_EN for backward-taken /
// forward-not-taken static prediction (branches) and always-taken JAL.

typedef struct packed {
    logic        monitor_valid;
    logic [63:0] monitor_order;
    logic [31:0] monitor_pc_rdata;
    logic [31:0] monitor_pc_wdata;
} rvfi_mon_t;

typedef struct packed {
    logic [31:0] pc;
    logic        branch_pred;
    logic [31:0] predicted_pc;
    rvfi_mon_t   rvfi;
} if_id_reg_t;

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic [31:0] inst,
    output if_id_reg_t  if_id_reg
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // r_pc is the fetch PC; while an instruction sits in WAIT/HOLD it is
    // also that instruction's PC. r_out_pc is the PC of the presented word.
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_valid;
    logic [31:0] r_out_pc;
    logic [31:0] r_next_pc;
    logic        r_branch_pred;
    logic [63:0] r_order;

    logic        w_pred_taken;
    logic [31:0] w_next_pc;
    logic        w_resp_take;
    logic        w_consume;
    logic        w_issue;

`ifdef IF_STATIC_PRED_EN
    localparam logic [6:0] OP_B_BR  = 7'b1100011;
    localparam logic [6:0] OP_B_JAL = 7'b1101111;

    logic [31:0] w_b_imm;
    logic [31:0] w_j_imm;

    assign w_b_imm = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                      imem_rdata[11:8], 1'b0};
    assign w_j_imm = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                      imem_rdata[30:21], 1'b0};

    // Static prediction on the returning word: backward branches and JAL taken.
    always_comb begin
        w_pred_taken = 1'b0;
        w_next_pc    = r_pc + 32'd4;
        if (imem_rdata[6:0] == OP_B_BR && imem_rdata[31]) begin
            w_pred_taken = 1'b1;
            w_next_pc    = r_pc + w_b_imm;
        end else if (imem_rdata[6:0] == OP_B_JAL) begin
            w_pred_taken = 1'b1;
            w_next_pc    = r_pc + w_j_imm;
        end
    end
`else
    assign w_pred_taken = 1'b0;
    assign w_next_pc    = r_pc + 32'd4;
`endif

    // A response is only kept in WAIT and only if no redirect squashes it.
    assign w_resp_take = (r_state == S_WAIT) && imem_resp && !redirect;
    // Decode takes the presented word; a redirect marks it wrong-path.
    assign w_consume   = r_valid && !stall && !redirect;
    // A new request is held back while an unconsumed word is still stalled,
    // so the next response can never overwrite it.
    assign w_issue     = (r_state == S_FETCH) && !rst && !redirect &&
                         !(r_valid && stall);

    assign imem_addr  = r_pc;
    assign imem_rmask = w_issue ? 4'hf : 4'h0;
    assign inst       = r_valid ? r_inst : NOP;

    assign if_id_reg.pc                    = r_out_pc;
    assign if_id_reg.branch_pred           = r_branch_pred;
    assign if_id_reg.predicted_pc          = r_next_pc;
    assign if_id_reg.rvfi.monitor_valid    = r_valid;
    assign if_id_reg.rvfi.monitor_order    = r_order;
    assign if_id_reg.rvfi.monitor_pc_rdata = r_out_pc;
    assign if_id_reg.rvfi.monitor_pc_wdata = r_next_pc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; redirect outranks stall everywhere.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_issue) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    w_state_next = imem_resp ? S_FETCH : S_DISCARD;
                end else if (imem_resp) begin
                    w_state_next = stall ? S_HOLD : S_FETCH;
                end
            end
            S_HOLD: begin
                if (redirect || !stall) begin
                    w_state_next = S_FETCH;
                end
            end
            S_DISCARD: begin
                if (imem_resp) begin
                    w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    // Fetch PC, output register and retirement-order counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inst        <= NOP;
            r_valid       <= 1'b0;
            r_out_pc      <= RESET_PC;
            r_next_pc     <= 32'h0;
            r_branch_pred <= 1'b0;
            r_order       <= 64'h0;
        end else begin
            if (redirect) begin
                r_pc <= redirect_pc;
            end else if (w_resp_take && !stall) begin
                r_pc <= w_next_pc;
            end else if (r_state == S_HOLD && !stall) begin
                r_pc <= r_next_pc;
            end

            if (redirect) begin
                r_valid <= 1'b0;
            end else if (w_resp_take) begin
                r_valid <= 1'b1;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end

            if (w_resp_take) begin
                r_inst        <= imem_rdata;
                r_out_pc      <= r_pc;
                r_next_pc     <= w_next_pc;
                r_branch_pred <= w_pred_taken;
            end

            if (w_consume) begin
                r_order <= r_order + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, straight-line fetch, stall,
// redirect with an outstanding request, redirect+resp+stall, wrap-around
// and the static-prediction case (expectations follow IF_STATIC_PRED_EN).

module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] inst;
    if_id_reg_t  if_id_reg;

    int n_cmp;
    int n_err;

    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] BEQ_M8  = 32'hfe000ce3;  // beq x0,x0,-8
`ifdef IF_STATIC_PRED_EN
    localparam logic        EXP_BP  = 1'b1;
    localparam logic [31:0] EXP_NPC = 32'h1eceb008;
`else
    localparam logic        EXP_BP  = 1'b0;
    localparam logic [31:0] EXP_NPC = 32'h1eceb014;
`endif

    if_fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .inst       (inst),
        .if_id_reg  (if_id_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: low byte 0x13 keeps every word a non-branch ALU op.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are changed just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_rdata = 32'h0; imem_resp = 1'b0;
        step(); step(); step();

        // Reset values
        settle();
        chk("rst_rmask", {60'h0, imem_rmask}, 64'h0);
        chk("rst_addr", {32'h0, imem_addr}, {32'h0, 32'h1eceb000});
        chk("rst_inst", {32'h0, inst}, {32'h0, NOP});
        chk("rst_valid", {63'h0, if_id_reg.rvfi.monitor_valid}, 64'h0);
        chk("rst_order", if_id_reg.rvfi.monitor_order, 64'h0);
        chk("rst_bpred", {63'h0, if_id_reg.branch_pred}, 64'h0);
        chk("rst_ppc", {32'h0, if_id_reg.predicted_pc}, 64'h0);

        rst = 1'b0;
        settle();
        // C0: first request right after reset release
        chk("c0_addr", {32'h0, imem_addr}, {32'h0, 32'h1eceb000});
        chk("c0_rmask", {60'h0, imem_rmask}, 64'hf);
        step();
        // C1: WAIT, response with word 0
        chk("c1_rmask", {60'h0, imem_rmask}, 64'h0);
        chk("c1_addr", {32'h0, imem_addr}, {32'h0, 32'h1eceb000});
        imem_resp = 1'b1; imem_rdata = mem(32'h1eceb000);
        step();
        imem_resp = 1'b0;
        settle();
        // C2: word 0 visible, fetch of 004 issued
        chk("c2_inst", {32'h0, inst}, {32'h0, mem(32'h1eceb000)});
        chk("c2_valid", {63'h0, if_id_reg.rvfi.monitor_valid}, 64'h1);
        chk("c2_order", if_id_reg.rvfi.monitor_order, 64'd0);
        chk("c2_pc", {32'h0, if_id_reg.pc}, {32'h0, 32'h1eceb000});
        chk("c2_addr", {32'h0, imem_addr}, {32'h0, 32'h1eceb004});
        chk("c2_rmask", {60'h0, imem_rmask}, 64'hf);
        step();
        // C3: response for 004 with stall asserted (stall cycle 1 of 3)
        imem_resp = 1'b1; imem_rdata = mem(32'h1eceb004); stall = 1'b1;
        step();
        imem_resp = 1'b0;
        settle();
        // C4, C5: HOLD, frozen
        chk("c4_inst", {32'h0, inst}, {32'h0, mem(32'h1eceb004)});
        chk("c4_pc", {32'h0, if_id_reg.pc}, {32'h0, 32'h1eceb004});
        chk("c4_order", if_id_reg.rvfi.monitor_order, 64'd1);
        chk("c4_rmask", {60'h0, imem_rmask}, 64'h0);
        step();
        chk("c5_inst", {32'h0, inst}, {32'h0, mem(32'h1eceb004)});
        chk("c5_order", if_id_reg.rvfi.monitor_order, 64'd1);
        chk("c5_rmask", {60'h0, imem_rmask}, 64'h0);
        step();
        stall = 1'b0;
        settle();
        // C6: stall released, word 004 consumed this cycle
        chk("c6_inst", {32'h0, inst}, {32'h0, mem(32'h1eceb004)});
        chk("c6_rmask", {60'h0, imem_rmask}, 64'h0);
        step();
        // C7: fetch of 008
        chk("c7_addr", {32'h0, imem_addr}, {32'h0, 32'h1eceb008});
        chk("c7_rmask", {60'h0, imem_rmask}, 64'hf);
        chk("c7_order", if_id_reg.rvfi.monitor_order, 64'd2);
        chk("c7_inst", {32'h0, inst}, {32'h0, NOP});
        step();
        // C8: response 008
        imem_resp = 1'b1; imem_rdata = mem(32'h1eceb008);
        step();
        imem_resp = 1'b0;
        settle();
        // C9: word 008 visible, fetch of 00c
        chk("c9_inst", {32'h0, inst}, {32'h0, mem(32'h1eceb008)});
        chk("c9_order", if_id_reg.rvfi.monitor_order, 64'd2);
        chk("c9_ppc", {32'h0, if_id_reg.predicted_pc}, {32'h0, 32'h1eceb00c});
        chk("c9_wdata", {32'h0, if_id_reg.rvfi.monitor_pc_wdata}, {32'h0, 32'h1eceb00c});
        chk("c9_addr", {32'h0, imem_addr}, {32'h0, 32'h1eceb00c});
        step();
        // C10: redirect while request to 00c is outstanding
        redirect = 1'b1; redirect_pc = 32'h1eceb100;
        step();
        redirect = 1'b0;
        settle();
        // C11: DISCARD
        chk("c11_valid", {63'h0, if_id_reg.rvfi.monitor_valid}, 64'h0);
        chk("c11_rmask", {60'h0, imem_rmask}, 64'h0);
        step();
        // C12: late response is dropped
        imem_resp = 1'b1; imem_rdata = mem(32'h1eceb00c);
        step();
        imem_resp = 1'b0;
        settle();
        // C13: request to redirect target
        chk("c13_addr", {32'h0, imem_addr}, {32'h0, 32'h1eceb100});
        chk("c13_rmask", {60'h0, imem_rmask}, 64'hf);
        chk("c13_valid", {63'h0, if_id_reg.rvfi.monitor_valid}, 64'h0);
        chk("c13_inst", {32'h0, inst}, {32'h0, NOP});
        chk("c13_order", if_id_reg.rvfi.monitor_order, 64'd3);
        step();
        // C14: redirect, resp and stall together
        redirect = 1'b1; redirect_pc = 32'hfffffffc; stall = 1'b1;
        imem_resp = 1'b1; imem_rdata = mem(32'h1eceb100);
        step();
        redirect = 1'b0; stall = 1'b0; imem_resp = 1'b0;
        settle();
        // C15: squashed, fetch at fffffffc
        chk("c15_addr", {32'h0, imem_addr}, {32'h0, 32'hfffffffc});
        chk("c15_rmask", {60'h0, imem_rmask}, 64'hf);
        chk("c15_valid", {63'h0, if_id_reg.rvfi.monitor_valid}, 64'h0);
        chk("c15_inst", {32'h0, inst}, {32'h0, NOP});
        chk("c15_order", if_id_reg.rvfi.monitor_order, 64'd3);
        step();
        // C16: response at the top of the address space
        imem_resp = 1'b1; imem_rdata = mem(32'hfffffffc);
        step();
        imem_resp = 1'b0;
        settle();
        // C17: wrap to 0
        chk("c17_addr", {32'h0, imem_addr}, 64'h0);
        chk("c17_inst", {32'h0, inst}, {32'h0, mem(32'hfffffffc)});
        chk("c17_pc", {32'h0, if_id_reg.rvfi.monitor_pc_rdata}, {32'h0, 32'hfffffffc});
        chk("c17_wdata", {32'h0, if_id_reg.rvfi.monitor_pc_wdata}, 64'h0);
        step();
        // C18: redirect coincident with response
        redirect = 1'b1; redirect_pc = 32'h1eceb010;
        imem_resp = 1'b1; imem_rdata = mem(32'h0);
        step();
        redirect = 1'b0; imem_resp = 1'b0;
        settle();
        // C19: fetch of the branch
        chk("c19_addr", {32'h0, imem_addr}, {32'h0, 32'h1eceb010});
        chk("c19_order", if_id_reg.rvfi.monitor_order, 64'd4);
        step();
        // C20: beq -8 returned
        imem_resp = 1'b1; imem_rdata = BEQ_M8;
        step();
        imem_resp = 1'b0;
        settle();
        // C21: prediction result
        chk("c21_inst", {32'h0, inst}, {32'h0, BEQ_M8});
        chk("c21_pc", {32'h0, if_id_reg.pc}, {32'h0, 32'h1eceb010});
        chk("c21_bpred", {63'h0, if_id_reg.branch_pred}, {63'h0, EXP_BP});
        chk("c21_ppc", {32'h0, if_id_reg.predicted_pc}, {32'h0, EXP_NPC});
        chk("c21_addr", {32'h0, imem_addr}, {32'h0, EXP_NPC});
        chk("c21_rmask", {60'h0, imem_rmask}, 64'hf);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
